// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    localparam int unsigned CNT_W          = 6;
    localparam int unsigned REG_W          = 5;
    localparam int unsigned MUL_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } en_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } flush_t;

    localparam en_t EN_ALL = '{
        pc: 1'b1, ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b1
    };

    localparam flush_t FL_NONE = '{
        ifid: 1'b0, idex: 1'b0, exmem: 1'b0, memwb: 1'b0
    };

    // Freeze PC..EX, push a bubble into MEM, let MEM/WB drain.
    localparam en_t MD_STALL_EN = '{
        pc: 1'b0, ifid: 1'b0, idex: 1'b0, exmem: 1'b1, memwb: 1'b1
    };

    localparam flush_t MD_STALL_FL = '{
        ifid: 1'b0, idex: 1'b0, exmem: 1'b1, memwb: 1'b0
    };

    localparam en_t LU_STALL_EN = '{
        pc: 1'b0, ifid: 1'b0, idex: 1'b1, exmem: 1'b1, memwb: 1'b1
    };

    localparam flush_t LU_STALL_FL = '{
        ifid: 1'b0, idex: 1'b1, exmem: 1'b0, memwb: 1'b0
    };

    localparam flush_t BR_FL = '{
        ifid: 1'b1, idex: 1'b1, exmem: 1'b0, memwb: 1'b0
    };

    // Counter preload: the start cycle itself is the first of N EX cycles.
    function automatic logic [CNT_W-1:0] md_load(
        input logic        is_div,
        input int unsigned mul_cycles,
        input int unsigned div_cycles
    );
        int unsigned n;
        n = is_div ? div_cycles : mul_cycles;
        return CNT_W'(n - 2);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the ID sources and the EX load target.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_uses_rs_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_write_reg_i,
    output logic             load_use_o
);

    logic rs_hit;
    logic rt_hit;
    logic wr_valid;

    assign rs_hit   = id_uses_rs_i && (id_rs_i == ex_write_reg_i);
    assign rt_hit   = id_uses_rt_i && (id_rt_i == ex_write_reg_i);
    // $zero is never a real dependency.
    assign wr_valid = (ex_write_reg_i != '0);

    assign load_use_o = ex_is_load_i && wr_valid && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use, MUL/DIV
// occupancy of EX, branch redirects and WB interrupt/ERET redirects.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_md_start,
    input  logic             ex_md_is_div,
    input  logic             ex_branch_taken,
    input  logic             wb_int_req,
    input  logic             wb_eret,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             md_busy
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic   load_use;
    logic   redirect;
    en_t    en;
    flush_t fl;

    hazard_detect u_hazard (
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_uses_rs_i   (id_uses_rs),
        .id_uses_rt_i   (id_uses_rt),
        .ex_is_load_i   (ex_is_load),
        .ex_write_reg_i (ex_write_reg),
        .load_use_o     (load_use)
    );

    // The CP0 request stays high for a cycle after it is taken.
    assign redirect = wb_eret ||
                      (wb_int_req && (state_q != ST_HOLDOFF));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        en      = EN_ALL;
        fl      = FL_NONE;
        state_d = state_q;
        cnt_d   = cnt_q;

        if (redirect) begin
            fl      = '1;
            state_d = ST_HOLDOFF;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_MD_WAIT: begin
                    if (cnt_q != '0) begin
                        en    = MD_STALL_EN;
                        fl    = MD_STALL_FL;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    if (ex_md_start) begin
                        en      = MD_STALL_EN;
                        fl      = MD_STALL_FL;
                        state_d = ST_MD_WAIT;
                        cnt_d   = md_load(ex_md_is_div,
                                          MUL_CYCLES,
                                          DIV_CYCLES);
                    end else if (load_use) begin
                        en = LU_STALL_EN;
                        fl = LU_STALL_FL;
                    end else if (ex_branch_taken) begin
                        fl = BR_FL;
                    end
                end
            endcase
        end

        // Hold the whole pipeline cleared while reset is asserted.
        if (!rst_n) begin
            en = '0;
            fl = '1;
        end
    end

    assign pc_en       = en.pc;
    assign ifid_en     = en.ifid;
    assign idex_en     = en.idex;
    assign exmem_en    = en.exmem;
    assign memwb_en    = en.memwb;
    assign ifid_flush  = fl.ifid;
    assign idex_flush  = fl.idex;
    assign exmem_flush = fl.exmem;
    assign memwb_flush = fl.memwb;
    assign md_busy     = (state_q == ST_MD_WAIT);

endmodule
